// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample stream and its receive-side checker.
package fir_pkg;

    localparam int unsigned FIR_DW  = 8;
    localparam int unsigned FIR_APW = 4;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } fir_chk_state_t;

endpackage : fir_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count register: clear first, then increment unless already at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/fir_checker.sv
// Self-synchronising checker for the incrementing FIR sample stream and its ap nibble.
module fir_checker
    import fir_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [FIR_DW-1:0] out_i,
    input  logic [FIR_APW-1:0] ap_i,
    input  logic              clr_i,
    output logic              locked_o,
    output logic              seq_err_o,
    output logic              ap_err_o,
    output logic [FIR_DW-1:0] exp_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned LW = $clog2(LOSS_CNT + 1);

    fir_chk_state_t    state;
    fir_chk_state_t    state_n;
    logic [FIR_DW-1:0] prev;
    logic [FIR_DW-1:0] prev_n;
    logic              have_prev;
    logic              have_prev_n;
    logic [MW-1:0]     match_cnt;
    logic [MW-1:0]     match_cnt_n;
    logic [LW-1:0]     miss_cnt;
    logic [LW-1:0]     miss_cnt_n;
    logic [FIR_DW-1:0] exp_n;
    logic              seq_err_n;
    logic              ap_err_n;
    logic              err_inc_c;

    // Compare the incoming sample and compute next-state values for the hunt/track machine.
    always_comb begin
        state_n     = state;
        prev_n      = prev;
        have_prev_n = have_prev;
        match_cnt_n = match_cnt;
        miss_cnt_n  = miss_cnt;
        exp_n       = exp_o;
        seq_err_n   = 1'b0;
        ap_err_n    = 1'b0;

        if (valid_i) begin
            ap_err_n = (ap_i != out_i[FIR_APW-1:0]);

            case (state)
                HUNT: begin
                    prev_n = out_i;
                    if (!have_prev) begin
                        have_prev_n = 1'b1;
                        match_cnt_n = '0;
                    end else if (out_i == prev + FIR_DW'(1)) begin
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state_n     = TRACK;
                            exp_n       = out_i + FIR_DW'(1);
                            miss_cnt_n  = '0;
                            match_cnt_n = '0;
                        end else begin
                            match_cnt_n = match_cnt + MW'(1);
                        end
                    end else begin
                        match_cnt_n = '0;
                    end
                end

                TRACK: begin
                    // Flywheel: expectation advances regardless of what arrived.
                    exp_n = exp_o + FIR_DW'(1);
                    if (out_i == exp_o) begin
                        miss_cnt_n = '0;
                    end else begin
                        seq_err_n = 1'b1;
                        if (miss_cnt == LW'(LOSS_CNT - 1)) begin
                            state_n     = HUNT;
                            have_prev_n = 1'b1;
                            prev_n      = out_i;
                            match_cnt_n = '0;
                            miss_cnt_n  = '0;
                        end else begin
                            miss_cnt_n = miss_cnt + LW'(1);
                        end
                    end
                end

                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    assign err_inc_c = seq_err_n | ap_err_n;

    // State, tracking registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            prev      <= '0;
            have_prev <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            exp_o     <= '0;
            locked_o  <= 1'b0;
            seq_err_o <= 1'b0;
            ap_err_o  <= 1'b0;
        end else begin
            state     <= state_n;
            prev      <= prev_n;
            have_prev <= have_prev_n;
            match_cnt <= match_cnt_n;
            miss_cnt  <= miss_cnt_n;
            exp_o     <= exp_n;
            locked_o  <= (state_n == TRACK);
            seq_err_o <= seq_err_n;
            ap_err_o  <= ap_err_n;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .inc(err_inc_c),
        .clr(clr_i),
        .cnt(err_cnt_o)
    );

endmodule : fir_checker

// File: tb/tb_fir_checker.sv
// Directed self-checking bench for fir_checker (default parameters plus a CNT_W=2 instance).
module tb_fir_checker;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [7:0]  out_i;
    logic [3:0]  ap_i;
    logic        clr_i;

    logic        locked_o;
    logic        seq_err_o;
    logic        ap_err_o;
    logic [7:0]  exp_o;
    logic [15:0] err_cnt_o;

    logic        locked2;
    logic        seq_err2;
    logic        ap_err2;
    logic [7:0]  exp2;
    logic [1:0]  err_cnt2;

    int checks = 0;
    int errors = 0;

    fir_checker dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .out_i    (out_i),
        .ap_i     (ap_i),
        .clr_i    (clr_i),
        .locked_o (locked_o),
        .seq_err_o(seq_err_o),
        .ap_err_o (ap_err_o),
        .exp_o    (exp_o),
        .err_cnt_o(err_cnt_o)
    );

    fir_checker #(
        .CNT_W(2)
    ) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .out_i    (out_i),
        .ap_i     (ap_i),
        .clr_i    (clr_i),
        .locked_o (locked2),
        .seq_err_o(seq_err2),
        .ap_err_o (ap_err2),
        .exp_o    (exp2),
        .err_cnt_o(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic se, input logic ae,
                           input logic [7:0] ex, input logic [15:0] cn);
        chk({tag, ".locked"},  32'(locked_o),  32'(lk));
        chk({tag, ".seq_err"}, 32'(seq_err_o), 32'(se));
        chk({tag, ".ap_err"},  32'(ap_err_o),  32'(ae));
        chk({tag, ".exp"},     32'(exp_o),     32'(ex));
        chk({tag, ".err_cnt"}, 32'(err_cnt_o), 32'(cn));
    endtask

    // Present one valid sample, then sample outputs 1 time unit after the capturing edge.
    task automatic send(input logic [7:0] v, input logic [3:0] a, input logic c);
        @(negedge clk);
        valid_i = 1'b1;
        out_i   = v;
        ap_i    = a;
        clr_i   = c;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        clr_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        out_i   = '0;
        ap_i    = '0;
        clr_i   = 1'b0;
        idle(3);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lock on 0x10..0x14
        for (int v = 'h10; v <= 'h13; v++) send(8'(v), 4'(v), 1'b0);
        chk("lock.before_last", 32'(locked_o), 32'd0);
        send(8'h14, 4'h4, 1'b0);
        chk_all("lock", 1'b1, 1'b0, 1'b0, 8'h15, 16'd0);

        // Run up to 0xFE, then cross the wrap
        for (int v = 'h15; v <= 'hFD; v++) send(8'(v), 4'(v), 1'b0);
        chk_all("pre_wrap", 1'b1, 1'b0, 1'b0, 8'hFE, 16'd0);
        send(8'hFE, 4'hE, 1'b0);
        send(8'hFF, 4'hF, 1'b0);
        send(8'h00, 4'h0, 1'b0);
        send(8'h01, 4'h1, 1'b0);
        chk_all("wrap", 1'b1, 1'b0, 1'b0, 8'h02, 16'd0);

        // Single sequence error with flywheel
        for (int v = 'h02; v <= 'h1F; v++) send(8'(v), 4'(v), 1'b0);
        chk("pre_20.exp", 32'(exp_o), 32'h20);
        send(8'h20, 4'h0, 1'b0);
        chk_all("seq_ok", 1'b1, 1'b0, 1'b0, 8'h21, 16'd0);
        send(8'h55, 4'h5, 1'b0);
        chk_all("seq_bad", 1'b1, 1'b1, 1'b0, 8'h22, 16'd1);
        send(8'h22, 4'h2, 1'b0);
        chk_all("seq_after", 1'b1, 1'b0, 1'b0, 8'h23, 16'd1);

        // Clear on an idle cycle, then three misses drop lock
        @(negedge clk);
        clr_i = 1'b1;
        idle(1);
        clr_i = 1'b0;
        chk_all("clr_idle", 1'b1, 1'b0, 1'b0, 8'h23, 16'd0);
        send(8'h80, 4'h0, 1'b0);
        chk_all("miss1", 1'b1, 1'b1, 1'b0, 8'h24, 16'd1);
        send(8'h81, 4'h1, 1'b0);
        chk_all("miss2", 1'b1, 1'b1, 1'b0, 8'h25, 16'd2);
        send(8'h82, 4'h2, 1'b0);
        chk("miss3.locked",  32'(locked_o),  32'd0);
        chk("miss3.seq_err", 32'(seq_err_o), 32'd1);
        chk("miss3.err_cnt", 32'(err_cnt_o), 32'd3);

        // Relock from the last miss value
        send(8'h83, 4'h3, 1'b0);
        send(8'h84, 4'h4, 1'b0);
        send(8'h85, 4'h5, 1'b0);
        chk("relock.before", 32'(locked_o), 32'd0);
        send(8'h86, 4'h6, 1'b0);
        chk_all("relock", 1'b1, 1'b0, 1'b0, 8'h87, 16'd3);

        // ap checks: ap only, both together, clear against an error
        for (int v = 'h87; v <= 'h139; v++) send(8'(v), 4'(v), 1'b0);
        chk("pre_3a.exp", 32'(exp_o), 32'h3A);
        send(8'h3A, 4'h5, 1'b0);
        chk_all("ap_only", 1'b1, 1'b0, 1'b1, 8'h3B, 16'd4);
        send(8'h50, 4'h1, 1'b0);
        chk_all("ap_and_seq", 1'b1, 1'b1, 1'b1, 8'h3C, 16'd5);
        send(8'h3C, 4'h0, 1'b1);
        chk_all("clr_vs_err", 1'b1, 1'b0, 1'b1, 8'h3D, 16'd0);
        idle(1);
        chk_all("idle_no_pulse", 1'b1, 1'b0, 1'b0, 8'h3D, 16'd0);

        // Asynchronous reset between edges while in TRACK
        send(8'h3D, 4'hD, 1'b0);
        chk("pre_rst.locked", 32'(locked_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lock run with valid gaps; first sample after reset starts the run
        send(8'hF0, 4'h0, 1'b0);
        idle(1);
        send(8'hF1, 4'h1, 1'b0);
        idle(3);
        send(8'hF2, 4'h2, 1'b0);
        idle(5);
        send(8'hF3, 4'h3, 1'b0);
        idle(2);
        chk_all("gap_hunt", 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        send(8'hF4, 4'h4, 1'b0);
        chk_all("gap_lock", 1'b1, 1'b0, 1'b0, 8'hF5, 16'd0);

        // Saturation on the CNT_W=2 instance via ap errors
        send(8'hF5, 4'h0, 1'b0);
        chk("sat1", 32'(err_cnt2), 32'd1);
        send(8'hF6, 4'h0, 1'b0);
        chk("sat2", 32'(err_cnt2), 32'd2);
        send(8'hF7, 4'h0, 1'b0);
        chk("sat3", 32'(err_cnt2), 32'd3);
        send(8'hF8, 4'h0, 1'b0);
        chk("sat_hold", 32'(err_cnt2), 32'd3);
        chk("sat_wide", 32'(err_cnt_o), 32'd4);
        chk("sat.locked", 32'(locked2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fir_checker

// File: doc/fir_checker.md
# fir_checker

Receive-side checker for the 8-bit incrementing sample stream produced by the team's FIR pipeline (`out` plus its 4-bit `ap` nibble). It self-synchronises to the stream without knowing the loaded seed. Once locked, it flags every sample that breaks the +1 (mod 256) sequence and every sample whose `ap` nibble disagrees with `out[3:0]`. It sits directly downstream of the FIR pipeline as an on-chip integrity monitor; its error counter is readable by the host.

## Interface
- `LOCK_CNT`, default 4: consecutive +1 transitions required to lock (≥1).
- `LOSS_CNT`, default 3: consecutive sequence misses in TRACK that drop lock (≥1).
- `CNT_W`, default 16: error counter width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_i` in 1: `out_i`/`ap_i` carry a new sample this cycle.
- `out_i` in 8: sample value.
- `ap_i` in 4: sample low nibble, as sent.
- `clr_i` in 1: synchronous clear of `err_cnt_o`.
- `locked_o` out 1: high while in TRACK.
- `seq_err_o` out 1: one-cycle pulse on a sequence mismatch in TRACK.
- `ap_err_o` out 1: one-cycle pulse on an `ap` mismatch, in any state.
- `exp_o` out 8: expected value of the next sample (valid in TRACK).
- `err_cnt_o` out CNT_W: saturating error count.

## Operation
- States: HUNT, TRACK. Reset enters HUNT.
- Internal registers: `prev` (8b), `have_prev` (1b), `match_cnt` (0..LOCK_CNT), `miss_cnt` (0..LOSS_CNT).
- A cycle with `valid_i`=0 changes no state or counter and raises no pulse.
- HUNT, valid sample:
  - If `have_prev`=0: store `prev`, set `have_prev`, `match_cnt`=0.
  - Else if `out_i == prev+1` (8-bit wrap, so 0xFF→0x00 counts as a match): `match_cnt`++.
  - Else: `match_cnt`=0.
  - In all cases `prev` ← `out_i`.
  - When `match_cnt` reaches LOCK_CNT: enter TRACK, `exp_o` ← `out_i+1`, `miss_cnt`=0.
- TRACK, valid sample:
  - Match (`out_i == exp_o`): `miss_cnt`=0.
  - Mismatch: `seq_err_o` pulses, `miss_cnt`++.
  - Flywheel rule: `exp_o` ← `exp_o+1` on every valid sample, matched or not. There is no re-alignment to the received value.
  - When `miss_cnt` reaches LOSS_CNT: return to HUNT, `have_prev`=1, `prev`=`out_i`, `match_cnt`=0.
- `ap` check: on any valid sample, `ap_i != out_i[3:0]` pulses `ap_err_o`. This applies in both states.
- Error counter:
  - Increments by exactly 1 per valid sample with `seq_err` or `ap_err` (both together count as 1).
  - Saturates at 2^CNT_W−1.
  - `clr_i` takes precedence over a same-cycle increment; the result is 0.
  - `clr_i` does not affect the state machine.

## Timing
- All outputs are registered. Reset values: `locked_o`=0, `seq_err_o`=0, `ap_err_o`=0, `exp_o`=0x00, `err_cnt_o`=0. Internal: `have_prev`=0, counters 0.
- Latency: 1 cycle. The response to the sample accepted at edge N is visible after edge N.
- Lock requires LOCK_CNT+1 valid samples. `locked_o` rises the cycle after the sample that completes the run.
- Unlock: `locked_o` falls the cycle after the LOSS_CNT-th consecutive miss. That final miss still pulses `seq_err_o` and still counts.
- Gaps in `valid_i` do not break a run or reset `miss_cnt`.
- Reset asserted mid-operation returns immediately to reset values. The first post-reset sample is treated as the first in HUNT.

## Structure
- Shared package `fir_pkg`:
  - state enum `fir_chk_state_t` {HUNT, TRACK};
  - sample width `FIR_DW`=8 and nibble width `FIR_APW`=4, shared with the FIR pipeline.
- One sub-module, `sat_counter` (parameter W; inputs `inc`, `clr`; clr-priority, saturating). It implements `err_cnt_o`.
- Everything else stays in one always block for the FSM/registers plus one combinational compare block.

## Test plan
- Reset then samples 0x10,0x11,0x12,0x13,0x14 with `ap`=low nibble → `locked_o`=1 after 5th sample, `exp_o`=0x15, no error pulses, `err_cnt_o`=0.
- Locked at `exp_o`=0xFE, send 0xFE,0xFF,0x00,0x01 → no errors (wrap-around), `exp_o`=0x02.
- Locked at `exp_o`=0x20, send 0x20,0x55,0x22 → single `seq_err_o` on 0x55, still locked, `err_cnt_o`=1, `exp_o`=0x23.
- Locked, send 3 consecutive wrong values → 3 `seq_err_o` pulses, `locked_o` drops after 3rd, `err_cnt_o`=3; then 4 further +1 transitions → relock.
- Send 0x3A with `ap_i`=0x5 while locked and in sequence → `ap_err_o` pulse only, `err_cnt_o`+1. Wrong value and wrong `ap` together → both pulses, count +1. Assert `clr_i` on the same cycle as an error → `err_cnt_o`=0.
- Valid gaps of 1–5 cycles interleaved in a lock run; async `rst` pulse mid-TRACK → gaps have no effect; reset returns all outputs to 0 and HUNT. Force `err_cnt_o` to saturate with CNT_W=2 → holds at 3.
